memreq_axi_bridge: RTL and testbench
====================================

Name: memreq_axi_bridge

Overview:
- Responder end of the single-outstanding memory request interface (mem_request_enable / mem_mode / mem_addr / mem_wdata / mem_wstrb -> mem_response_enable / mem_data) used by DMA-capable peripherals such as the virtio block controller.
- Converts each request into one AXI4-Lite master transaction toward main memory and returns the result as a single-cycle response pulse.
- Sits between one requesting peripheral and one AXI4-Lite memory port; it does no arbitration.

Parameters:
- ADDR_OFFSET, 32'h0, constant added modulo 2^32 to mem_addr before it is driven on AXI (window translation).
- FORCE_ALIGN, 1, when 1 forces AXI address bits [1:0] to 0; when 0 passes them through.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- mem_request_enable  in  1  request strobe, sampled on rising edge
- mem_mode  in  1  0 = read (MEMREQ_READ), 1 = write
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  write byte strobes
- mem_response_enable  out  1  one-cycle completion pulse
- mem_data  out  32  read data; valid while mem_response_enable=1
- mem_busy  out  1  high from request accept until the response pulse, inclusive
- mem_resp_error  out  1  valid with mem_response_enable; 1 if RRESP/BRESP != OKAY
- mem_overrun  out  1  sticky; set when a request arrives while busy
- axi_araddr  out  32, axi_arvalid  out  1, axi_arready  in  1, axi_arprot  out  3
- axi_rdata  in  32, axi_rresp  in  2, axi_rvalid  in  1, axi_rready  out  1
- axi_awaddr  out  32, axi_awvalid  out  1, axi_awready  in  1, axi_awprot  out  3
- axi_wdata  out  32, axi_wstrb  out  4, axi_wvalid  out  1, axi_wready  in  1
- axi_bresp  in  2, axi_bvalid  in  1, axi_bready  out  1

Behaviour:
- Reset (rstn=0, asynchronous): state IDLE; every output 0, including mem_data, the AXI addresses and data, and mem_overrun. axi_*prot is always 3'b000.
- Address: axi_addr = mem_addr + ADDR_OFFSET. If FORCE_ALIGN=1, bits [1:0] are cleared. The address is latched at accept.
- IDLE: on mem_request_enable=1, latch addr, wdata, wstrb and mode, and set mem_busy. Mode 0 goes to RD_ADDR; mode 1 goes to WR_REQ. AXI valids rise on the cycle after accept.
- RD_ADDR: axi_arvalid=1 until the cycle with arvalid&arready, then drop it and go to RD_DATA.
- RD_DATA: axi_rready=1. On rvalid&rready, latch rdata into mem_data and set error = (rresp!=0). Go to RESPOND.
- WR_REQ: axi_awvalid and axi_wvalid rise together. Each drops independently on its own handshake, tracked by aw_done and w_done flags. Completion in the same cycle or either order is legal.
  - When both flags are set (or both complete in the same cycle), go to WR_RESP.
- WR_RESP: axi_bready=1. On bvalid&bready, set error = (bresp!=0), set mem_data=0, and go to RESPOND.
- RESPOND: mem_response_enable=1 for exactly one cycle and mem_resp_error is driven. Next state is IDLE, where mem_busy=0.
- mem_data holds its last value until the next response. mem_resp_error holds its value until the next response.
- Earliest acceptance of a new request is the cycle after RESPOND. Back-to-back requests separated by 1 idle cycle must work.
- Once raised, an AXI valid never drops before its handshake. Latched address and data never change while a valid is high.
- A request while mem_busy=1, including during RESPOND, is ignored and sets mem_overrun; the in-flight transaction is unaffected. mem_overrun clears only on reset.
- Minimum read latency, accept to response pulse: arvalid 1 cycle after accept; with arready=1 and rvalid returned the cycle after AR, the response pulse comes 3 cycles after accept.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. No response pulse is issued for the aborted request.

Test Plan:
- Read, zero-wait slave: mem_addr=32'h8000_0010, mode 0, slave rdata=32'hCAFEBABE -> araddr=32'h8000_0010, one pulse 3 cycles after accept, mem_data=32'hCAFEBABE, mem_resp_error=0.
- Write, awready delayed 3 cycles and wready immediate, wstrb=4'b0011, wdata=32'h1234_5678 -> wvalid drops first and awvalid 3 cycles later; bready then high; single pulse with mem_data=0.
- Error and offset: ADDR_OFFSET=32'h1000, FORCE_ALIGN=1, mem_addr=32'h3 -> araddr=32'h1000; rresp=2'b10 -> mem_resp_error=1 on the pulse.
- Overrun: issue a second request 1 cycle after accepting a read -> the first read completes normally, no second AXI transaction occurs, mem_overrun=1 and remains 1.
- Back-to-back: write then read with 1 idle cycle between the response pulse and the next request -> two pulses, correct data, mem_overrun=0.
- Reset mid-read: deassert rstn while in RD_DATA -> all outputs 0 immediately; after release, a new read completes normally.

Source files
------------

// File: rtl/memreq_axi_bridge.sv
// Responder end of the single-outstanding memory request interface. Each request
// becomes one AXI4-Lite read or write, and the result comes back as a one-cycle pulse.
module memreq_axi_bridge #(
   parameter logic [31:0] ADDR_OFFSET = 32'h0,
   parameter bit          FORCE_ALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        mem_request_enable,
   input  logic        mem_mode,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_response_enable,
   output logic [31:0] mem_data,
   output logic        mem_busy,
   output logic        mem_resp_error,
   output logic        mem_overrun,
   output logic [31:0] axi_araddr,
   output logic        axi_arvalid,
   input  logic        axi_arready,
   output logic [2:0]  axi_arprot,
   input  logic [31:0] axi_rdata,
   input  logic [1:0]  axi_rresp,
   input  logic        axi_rvalid,
   output logic        axi_rready,
   output logic [31:0] axi_awaddr,
   output logic        axi_awvalid,
   input  logic        axi_awready,
   output logic [2:0]  axi_awprot,
   output logic [31:0] axi_wdata,
   output logic [3:0]  axi_wstrb,
   output logic        axi_wvalid,
   input  logic        axi_wready,
   input  logic [1:0]  axi_bresp,
   input  logic        axi_bvalid,
   output logic        axi_bready
);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESPOND} state_t;

   state_t      state;
   logic        aw_done, w_done;
   logic        aw_hs, w_hs;
   logic [31:0] xlat_addr;

   // Window translation wraps modulo 2^32.
   always_comb begin
      xlat_addr = mem_addr + ADDR_OFFSET;
      if (FORCE_ALIGN) xlat_addr[1:0] = 2'b00;
   end

   assign aw_hs      = axi_awvalid & axi_awready;
   assign w_hs       = axi_wvalid & axi_wready;
   assign axi_arprot = 3'b000;
   assign axi_awprot = 3'b000;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state               <= IDLE;
         aw_done             <= 1'b0;
         w_done              <= 1'b0;
         mem_response_enable <= 1'b0;
         mem_data            <= 32'h0;
         mem_busy            <= 1'b0;
         mem_resp_error      <= 1'b0;
         mem_overrun         <= 1'b0;
         axi_araddr          <= 32'h0;
         axi_arvalid         <= 1'b0;
         axi_rready          <= 1'b0;
         axi_awaddr          <= 32'h0;
         axi_awvalid         <= 1'b0;
         axi_wdata           <= 32'h0;
         axi_wstrb           <= 4'h0;
         axi_wvalid          <= 1'b0;
         axi_bready          <= 1'b0;
      end else begin
         mem_response_enable <= 1'b0;
         if (mem_request_enable && state != IDLE) mem_overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (mem_request_enable) begin
                  mem_busy <= 1'b1;
                  if (mem_mode) begin
                     axi_awaddr  <= xlat_addr;
                     axi_wdata   <= mem_wdata;
                     axi_wstrb   <= mem_wstrb;
                     axi_awvalid <= 1'b1;
                     axi_wvalid  <= 1'b1;
                     aw_done     <= 1'b0;
                     w_done      <= 1'b0;
                     state       <= WR_REQ;
                  end else begin
                     axi_araddr  <= xlat_addr;
                     axi_arvalid <= 1'b1;
                     state       <= RD_ADDR;
                  end
               end
            end
            RD_ADDR: begin
               if (axi_arready) begin
                  axi_arvalid <= 1'b0;
                  axi_rready  <= 1'b1;
                  state       <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (axi_rvalid) begin
                  axi_rready          <= 1'b0;
                  mem_data            <= axi_rdata;
                  mem_resp_error      <= (axi_rresp != 2'b00);
                  mem_response_enable <= 1'b1;
                  state               <= RESPOND;
               end
            end
            WR_REQ: begin
               // AW and W complete independently, in either order or together.
               if (aw_hs) begin
                  axi_awvalid <= 1'b0;
                  aw_done     <= 1'b1;
               end
               if (w_hs) begin
                  axi_wvalid <= 1'b0;
                  w_done     <= 1'b1;
               end
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  axi_bready <= 1'b1;
                  state      <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (axi_bvalid) begin
                  axi_bready          <= 1'b0;
                  mem_data            <= 32'h0;
                  mem_resp_error      <= (axi_bresp != 2'b00);
                  mem_response_enable <= 1'b1;
                  state               <= RESPOND;
               end
            end
            RESPOND: begin
               mem_busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memreq_axi_bridge.sv
// Scoreboard bench for memreq_axi_bridge: reactive AXI4-Lite slave with tunable
// wait states; expected responses are queued at request time and popped on each pulse.
module tb_memreq_axi_bridge;

   localparam logic [31:0] OFF = 32'h1000;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        mem_request_enable, mem_mode;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_response_enable, mem_busy, mem_resp_error, mem_overrun;
   logic [31:0] mem_data;
   logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
   logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
   logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
   logic [2:0]  axi_arprot, axi_awprot;
   logic [1:0]  axi_rresp, axi_bresp;
   logic [3:0]  axi_wstrb;

   memreq_axi_bridge #(.ADDR_OFFSET(OFF), .FORCE_ALIGN(1'b1)) dut (
      .clk(clk), .rstn(rstn),
      .mem_request_enable(mem_request_enable), .mem_mode(mem_mode),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_response_enable(mem_response_enable), .mem_data(mem_data),
      .mem_busy(mem_busy), .mem_resp_error(mem_resp_error), .mem_overrun(mem_overrun),
      .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_arprot(axi_arprot), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_awprot(axi_awprot), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          lat;
      int          drv;
   } exp_t;
   exp_t sb[$];

   int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0;
   logic [31:0] rd_val = 32'h0;
   logic [1:0]  rd_resp = 2'b00, wr_resp = 2'b00;
   logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0;
   logic [3:0]  exp_wstrb = 4'h0;
   int          ar_cnt = 0, aw_cnt = 0, w_drop = 0, aw_drop = 0;

   wire [146:0] outs = {mem_response_enable, mem_data, mem_busy, mem_resp_error, mem_overrun,
                        axi_araddr, axi_arvalid, axi_arprot, axi_rready,
                        axi_awaddr, axi_awvalid, axi_awprot, axi_wdata, axi_wstrb,
                        axi_wvalid, axi_bready};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic issue(input logic mode, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] ed, input logic ee,
                        input int lat);
      exp_t e;
      @(negedge clk);
      chk("idle_busy", mem_busy, 1'b0);
      mem_request_enable = 1'b1;
      mem_mode  = mode;
      mem_addr  = addr;
      mem_wdata = wd;
      mem_wstrb = st;
      exp_addr  = (addr + OFF) & 32'hFFFF_FFFC;
      exp_wdata = wd;
      exp_wstrb = st;
      e.data = ed; e.err = ee; e.lat = lat; e.drv = cyc;
      sb.push_back(e);
      @(negedge clk);
      mem_request_enable = 1'b0;
      chk("acc_busy", mem_busy, 1'b1);
   endtask

   task automatic wait_resp(input string tag);
      int n = 0;
      while (!mem_response_enable && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_done"}, n < 60, 1'b1);
   endtask

   // Response monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mem_response_enable) begin
            if (sb.size() == 0) chk("spurious_pulse", 1'b1, 1'b0);
            else begin
               e = sb.pop_front();
               chk("rsp_data", mem_data, e.data);
               chk("rsp_err", mem_resp_error, e.err);
               chk("rsp_busy", mem_busy, 1'b1);
               if (e.lat >= 0) chk("rsp_lat", cyc - e.drv, e.lat);
            end
         end
      end
   end

   // Read slave
   initial forever begin
      @(negedge clk);
      if (axi_arvalid) begin
         for (int i = 0; i < ar_wait; i++) begin
            @(negedge clk);
            chk("ar_hold", axi_arvalid, 1'b1);
         end
         chk("araddr", axi_araddr, exp_addr);
         axi_arready = 1'b1;
         @(negedge clk);
         axi_arready = 1'b0;
         ar_cnt++;
         chk("ar_drop", axi_arvalid, 1'b0);
         chk("rready", axi_rready, 1'b1);
         repeat (r_wait) @(negedge clk);
         axi_rvalid = 1'b1;
         axi_rdata  = rd_val;
         axi_rresp  = rd_resp;
         @(negedge clk);
         axi_rvalid = 1'b0;
      end
   end

   // Write slave
   initial forever begin
      @(negedge clk);
      if (axi_awvalid) begin
         chk("w_with_aw", axi_wvalid, 1'b1);
         fork
            begin
               for (int i = 0; i < aw_wait; i++) begin
                  @(negedge clk);
                  chk("aw_hold", axi_awvalid, 1'b1);
               end
               chk("awaddr", axi_awaddr, exp_addr);
               axi_awready = 1'b1;
               @(negedge clk);
               axi_awready = 1'b0;
               chk("aw_drop", axi_awvalid, 1'b0);
               aw_drop = cyc;
            end
            begin
               for (int j = 0; j < w_wait; j++) begin
                  @(negedge clk);
                  chk("w_hold", axi_wvalid, 1'b1);
               end
               chk("wdata", axi_wdata, exp_wdata);
               chk("wstrb", axi_wstrb, exp_wstrb);
               axi_wready = 1'b1;
               @(negedge clk);
               axi_wready = 1'b0;
               chk("w_drop", axi_wvalid, 1'b0);
               w_drop = cyc;
            end
         join
         aw_cnt++;
         chk("bready", axi_bready, 1'b1);
         axi_bvalid = 1'b1;
         axi_bresp  = wr_resp;
         @(negedge clk);
         axi_bvalid = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      mem_request_enable = 1'b0; mem_mode = 1'b0; mem_addr = 32'h0;
      mem_wdata = 32'h0; mem_wstrb = 4'h0;
      axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = 32'h0; axi_rresp = 2'b00;
      axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
      repeat (3) @(negedge clk);
      chk("rst_outs", |outs, 1'b0);
      rstn = 1'b1;

      // Zero-wait read, minimum latency
      rd_val = 32'hCAFEBABE; rd_resp = 2'b00;
      issue(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hCAFEBABE, 1'b0, 3);
      wait_resp("rd0");

      // Write, W accepted first, AW three cycles later
      aw_wait = 3; w_wait = 0; wr_resp = 2'b00;
      issue(1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 32'h0, 1'b0, -1);
      wait_resp("wr0");
      chk("aw_after_w", aw_drop - w_drop, 3);
      chk("aw_cnt1", aw_cnt, 1);

      // Error response, unaligned address with offset, AR wait states
      ar_wait = 2; r_wait = 1; rd_val = 32'h5555_AAAA; rd_resp = 2'b10;
      issue(1'b0, 32'h0000_0003, 32'h0, 4'h0, 32'h5555_AAAA, 1'b1, -1);
      wait_resp("rderr");
      repeat (2) @(negedge clk);
      chk("err_hold", mem_resp_error, 1'b1);
      chk("data_hold", mem_data, 32'h5555_AAAA);

      // Back-to-back write then read with one idle cycle between
      ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 2; wr_resp = 2'b00; rd_resp = 2'b00;
      issue(1'b1, 32'hFFFF_F004, 32'hDEAD_0001, 4'b1111, 32'h0, 1'b0, -1);
      wait_resp("b2b_wr");
      @(negedge clk);
      rd_val = 32'h0BAD_F00D;
      issue(1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 3);
      wait_resp("b2b_rd");
      chk("b2b_ovr", mem_overrun, 1'b0);
      chk("ar_cnt3", ar_cnt, 3);
      chk("aw_cnt2", aw_cnt, 2);

      // Overrun: second request while the first read is in flight
      r_wait = 1; rd_val = 32'h7777_0001;
      issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h7777_0001, 1'b0, -1);
      mem_request_enable = 1'b1; mem_mode = 1'b0; mem_addr = 32'h9999_9990;
      @(negedge clk);
      mem_request_enable = 1'b0;
      wait_resp("ovr");
      repeat (5) @(negedge clk);
      chk("ovr_set", mem_overrun, 1'b1);
      chk("ovr_ar_cnt", ar_cnt, 4);
      chk("ovr_sb_empty", sb.size(), 0);
      repeat (3) @(negedge clk);
      chk("ovr_sticky", mem_overrun, 1'b1);

      // Reset in RD_DATA
      r_wait = 4; rd_val = 32'h1111_2222;
      issue(1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'h1111_2222, 1'b0, -1);
      n = 0;
      while (!axi_rready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("midrst_in_rd", axi_rready, 1'b1);
      #2 rstn = 1'b0;
      #1 chk("midrst_outs", |outs, 1'b0);
      sb.delete();
      @(negedge clk);
      #2 rstn = 1'b1;
      repeat (8) @(negedge clk);
      chk("midrst_ovr_clr", mem_overrun, 1'b0);
      chk("midrst_idle", mem_busy, 1'b0);

      // Fresh read after reset
      r_wait = 0; rd_val = 32'hA5A5_5A5A;
      issue(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0, 3);
      wait_resp("post_rst");
      chk("ar_cnt6", ar_cnt, 6);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
